// File: rtl/alu_pipe.sv
// alu_pipe: pipelined RV32I-style integer ALU functional unit.
//
// The result is computed combinationally from the issue inputs, captured into
// stage 0 on an accepted issue and carried with its destination tag through
// STAGES register stages. Empty slots ahead of a stalled stage are filled, so
// bubbles collapse. flush clears every stage at the next edge.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   issue_valid/ready   issue handshake (ready is combinational from out_ready)
//   issue_func          ALU function code (see func_e)
//   issue_opa/opb       operands, XLEN bits
//   issue_tag           destination physical tag
//   flush               squash all in-flight ops and any op issued this cycle
//   out_valid/ready     result handshake towards the CDB arbiter
//   out_data/out_tag    result value and destination tag (last stage)
//   done_count          completed output handshakes since reset, wraps at 2^32
module alu_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_func,
    input  logic [XLEN-1:0]  issue_opa,
    input  logic [XLEN-1:0]  issue_opb,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      done_count
);

    localparam int unsigned SHW  = $clog2(XLEN);
    localparam int unsigned LAST = STAGES - 1;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_SLT  = 4'd2,
        FN_SLTU = 4'd3,
        FN_AND  = 4'd4,
        FN_OR   = 4'd5,
        FN_XOR  = 4'd6,
        FN_SLL  = 4'd7,
        FN_SRL  = 4'd8,
        FN_SRA  = 4'd9,
        FN_MIN  = 4'd10,
        FN_MAX  = 4'd11,
        FN_MINU = 4'd12,
        FN_MAXU = 4'd13
    } func_e;

    logic [STAGES-1:0] v_q, v_d;
    logic [XLEN-1:0]   data_q [STAGES];
    logic [XLEN-1:0]   data_d [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];
    logic [31:0]       done_q, done_d;

    logic [STAGES-1:0] move;
    logic              accept;
    logic [XLEN-1:0]   alu_res;

    // ALU
    logic [SHW-1:0] shamt;
    logic           lt_s, lt_u;

    always_comb begin
        shamt   = issue_opb[SHW-1:0];
        lt_s    = $signed(issue_opa) < $signed(issue_opb);
        lt_u    = issue_opa < issue_opb;
        alu_res = '1;
        case (func_e'(issue_func))
            FN_ADD:  alu_res = issue_opa + issue_opb;
            FN_SUB:  alu_res = issue_opa - issue_opb;
            FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            FN_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            FN_AND:  alu_res = issue_opa & issue_opb;
            FN_OR:   alu_res = issue_opa | issue_opb;
            FN_XOR:  alu_res = issue_opa ^ issue_opb;
            FN_SLL:  alu_res = issue_opa << shamt;
            FN_SRL:  alu_res = issue_opa >> shamt;
            FN_SRA:  alu_res = $signed(issue_opa) >>> shamt;
            FN_MIN:  alu_res = lt_s ? issue_opa : issue_opb;
            FN_MAX:  alu_res = lt_s ? issue_opb : issue_opa;
            FN_MINU: alu_res = lt_u ? issue_opa : issue_opb;
            FN_MAXU: alu_res = lt_u ? issue_opb : issue_opa;
            default: alu_res = '1;
        endcase
    end

    // Move chain, evaluated from the output back towards stage 0. The output
    // port behaves like an always-occupied stage that advances on out_ready.
    always_comb begin
        logic        carry;
        logic        v_next;
        int unsigned i;
        move   = '0;
        carry  = out_ready;
        v_next = 1'b1;
        for (int unsigned k = 0; k < STAGES; k++) begin
            i       = LAST - k;
            carry   = v_q[i] & (~v_next | carry);
            move[i] = carry;
            v_next  = v_q[i];
        end
    end

    assign issue_ready = ~v_q[0] | move[0];
    assign accept      = issue_valid & issue_ready;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        tag_d  = tag_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                if (accept) begin
                    v_d[0]    = 1'b1;
                    data_d[0] = alu_res;
                    tag_d[0]  = issue_tag;
                end else if (move[0]) begin
                    v_d[0] = 1'b0;
                end
            end else begin
                if (move[k-1]) begin
                    v_d[k]    = 1'b1;
                    data_d[k] = data_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                end else if (move[k]) begin
                    v_d[k] = 1'b0;
                end
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    assign out_valid  = v_q[LAST] & ~flush;
    assign out_data   = data_q[LAST];
    assign out_tag    = tag_q[LAST];
    assign done_count = done_q;

    always_comb begin
        done_d = done_q;
        if (out_valid && out_ready) begin
            done_d = done_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q    <= '0;
            done_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            v_q    <= v_d;
            done_q <= done_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (XLEN=32/STAGES=2 and a
// second XLEN=64/STAGES=1 instance). Accepted issues push the expected result
// to a queue; each output handshake pops and compares.
module tb_alu_pipe;

    localparam int unsigned ST = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  issue_func = '0;
    logic [31:0] issue_opa = '0;
    logic [31:0] issue_opb = '0;
    logic [5:0]  issue_tag = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [5:0]  out_tag;
    logic [31:0] done_count;

    logic        v64 = 1'b0;
    logic        rdy64;
    logic [3:0]  func64 = '0;
    logic [63:0] opa64 = '0;
    logic [63:0] opb64 = '0;
    logic [5:0]  tag64 = '0;
    logic        ov64;
    logic        ordy64 = 1'b1;
    logic [63:0] od64;
    logic [5:0]  ot64;
    logic [31:0] done64;

    always #5 clock = ~clock;

    alu_pipe #(.XLEN(32), .STAGES(ST), .TAG_W(6)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_func(issue_func), .issue_opa(issue_opa), .issue_opb(issue_opb),
        .issue_tag(issue_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .done_count(done_count)
    );

    alu_pipe #(.XLEN(64), .STAGES(1), .TAG_W(6)) u64 (
        .clock(clock), .reset(reset),
        .issue_valid(v64), .issue_ready(rdy64),
        .issue_func(func64), .issue_opa(opa64), .issue_opb(opb64),
        .issue_tag(tag64), .flush(1'b0),
        .out_valid(ov64), .out_ready(ordy64),
        .out_data(od64), .out_tag(ot64), .done_count(done64)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  t;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_done = '0;

    logic        hs, acc, obs_valid;
    logic [31:0] hs_data, obs_done;
    logic [5:0]  hs_tag;

    function automatic logic [31:0] model(logic [3:0] f, logic [31:0] a, logic [31:0] b);
        logic [4:0]  sh;
        logic [63:0] ext;
        logic [31:0] as, bs;
        sh  = b[4:0];
        as  = a ^ 32'h8000_0000;
        bs  = b ^ 32'h8000_0000;
        ext = {{32{a[31]}}, a} >> sh;
        case (f)
            4'd0:    model = a + b;
            4'd1:    model = a - b;
            4'd2:    model = (as < bs) ? 32'd1 : 32'd0;
            4'd3:    model = (a < b) ? 32'd1 : 32'd0;
            4'd4:    model = a & b;
            4'd5:    model = a | b;
            4'd6:    model = a ^ b;
            4'd7:    model = a << sh;
            4'd8:    model = a >> sh;
            4'd9:    model = ext[31:0];
            4'd10:   model = (as < bs) ? a : b;
            4'd11:   model = (as < bs) ? b : a;
            4'd12:   model = (a < b) ? a : b;
            4'd13:   model = (a < b) ? b : a;
            default: model = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       rnd_op = $urandom;
            1:       rnd_op = 32'h8000_0000;
            2:       rnd_op = 32'hFFFF_FFFF;
            default: rnd_op = $urandom_range(0, 40);
        endcase
    endfunction

    // One clock cycle: observe at the falling edge, record accepted issues,
    // then return 1 time unit after the next rising edge for new stimulus.
    task automatic cyc();
        exp_t e;
        @(negedge clock);
        obs_valid = out_valid;
        obs_done  = done_count;
        hs        = out_valid && out_ready;
        hs_data   = out_data;
        hs_tag    = out_tag;
        acc       = issue_valid && issue_ready && !flush;
        if (acc) begin
            e.d = model(issue_func, issue_opa, issue_opb);
            e.t = issue_tag;
            sbq.push_back(e);
        end
        if (hs) exp_done = exp_done + 32'd1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (out_valid !== 1'b0 || issue_ready !== 1'b1 || done_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_hold: valid=%b ready=%b done=%0d, required 0/1/0", out_valid, issue_ready, done_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc();
        vectors++;
        if (obs_valid !== 1'b0 || obs_done !== 32'd0 || issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: valid=%b done=%0d ready=%b, required 0/0/1", obs_valid, obs_done, issue_ready);
        end
    endtask

    task automatic test_add();
        exp_t e;
        out_ready   = 1'b1;
        issue_valid = 1'b1;
        issue_func  = 4'd0;
        issue_opa   = 32'h7FFF_FFFF;
        issue_opb   = 32'd1;
        issue_tag   = 6'd5;
        cyc();
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL add_accept: accepted=%b, required 1", acc);
        end
        issue_valid = 1'b0;
        cyc();
        vectors++;
        if (obs_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_early: out_valid=%b at +1, required 0", obs_valid);
        end
        cyc();
        vectors++;
        if (!hs || hs_data !== 32'h8000_0000 || hs_tag !== 6'd5) begin
            miscompares++;
            $display("FAIL add_result: hs=%b data=%h tag=%0d, required 1/80000000/5", hs, hs_data, hs_tag);
        end
        if (hs && sbq.size() > 0) e = sbq.pop_front();
        cyc();
        vectors++;
        if (obs_done !== 32'd1 || obs_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_done: done=%0d valid=%b, required 1/0", obs_done, obs_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [3:0]  fl [7] = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd13, 4'd15};
        logic [31:0] al [7] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0};
        logic [31:0] bl [7] = '{32'd7, 32'd1, 32'd1, 32'h21, 32'd3, 32'd3, 32'd0};
        logic [31:0] kx [7] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'hC000_0000,
                                32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int nout = 0;
        int first = 0;
        int last = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 16 && nout < 7; c++) begin
            if (c < 7) begin
                issue_valid = 1'b1;
                issue_func  = fl[c];
                issue_opa   = al[c];
                issue_opb   = bl[c];
                issue_tag   = 6'(10 + c);
            end else begin
                issue_valid = 1'b0;
            end
            cyc();
            if (c < 7) begin
                vectors++;
                if (!acc) begin
                    miscompares++;
                    $display("FAIL b2b_accept: op %0d accepted=%b, required 1", c, acc);
                end
            end
            if (hs) begin
                vectors++;
                if (nout == 0) first = c;
                last = c;
                e = (sbq.size() > 0) ? sbq.pop_front() : '0;
                if (hs_data !== kx[nout] || hs_data !== e.d || hs_tag !== e.t) begin
                    miscompares++;
                    $display("FAIL b2b_data: out %0d got %h/%0d, required %h/%0d", nout, hs_data, hs_tag, kx[nout], e.t);
                end
                nout++;
            end
        end
        vectors++;
        if (nout != 7 || first != ST || last - first != 6) begin
            miscompares++;
            $display("FAIL b2b_timing: outputs=%0d first=%0d span=%0d, required 7/%0d/6", nout, first, last - first, ST);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n_acc = 0;
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        issue_func  = 4'd0;
        issue_opb   = 32'd100;
        for (int i = 0; i < 6; i++) begin
            issue_opa = 32'(i);
            issue_tag = 6'(20 + i);
            cyc();
            if (acc) n_acc++;
        end
        vectors++;
        if (n_acc != ST || issue_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_fill: accepted=%0d ready=%b valid=%b, required %0d/0/1", n_acc, issue_ready, out_valid, ST);
        end
        issue_valid = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < ST; i++) begin
            cyc();
            vectors++;
            if (!hs || sbq.size() == 0) begin
                miscompares++;
                $display("FAIL bp_drain: cycle %0d hs=%b, required 1", i, hs);
            end else begin
                e = sbq.pop_front();
                if (hs_data !== e.d || hs_tag !== e.t) begin
                    miscompares++;
                    $display("FAIL bp_data: got %h/%0d, required %h/%0d", hs_data, hs_tag, e.d, e.t);
                end
            end
        end
        cyc();
        vectors++;
        if (hs || sbq.size() != 0 || obs_done !== exp_done) begin
            miscompares++;
            $display("FAIL bp_dup: hs=%b pending=%0d done=%0d, required 0/0/%0d", hs, sbq.size(), obs_done, exp_done);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   issued = 0;
        for (int c = 0; c < 600 && (issued < 60 || sbq.size() > 0); c++) begin
            issue_valid = (issued < 60) && ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            issue_func  = 4'($urandom_range(0, 15));
            issue_opa   = rnd_op();
            issue_opb   = rnd_op();
            issue_tag   = 6'($urandom_range(0, 63));
            cyc();
            if (acc) issued++;
            if (hs) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra: got %h, required no output", hs_data);
                end else begin
                    e = sbq.pop_front();
                    if (hs_data !== e.d || hs_tag !== e.t) begin
                        miscompares++;
                        $display("FAIL rand_data: got %h/%0d, required %h/%0d", hs_data, hs_tag, e.d, e.t);
                    end
                end
            end
        end
        issue_valid = 1'b0;
        out_ready   = 1'b1;
        cyc();
        vectors++;
        if (issued < 60 || sbq.size() != 0 || obs_done !== exp_done) begin
            miscompares++;
            $display("FAIL rand_end: issued=%0d pending=%0d done=%0d, required 60/0/%0d", issued, sbq.size(), obs_done, exp_done);
        end
    endtask

    task automatic test_flush();
        logic [31:0] done_before;
        done_before = done_count;
        out_ready   = 1'b1;
        issue_valid = 1'b1;
        issue_func  = 4'd5;
        issue_opa   = 32'h0F0;
        issue_opb   = 32'h00F;
        issue_tag   = 6'd1;
        cyc();
        issue_tag = 6'd2;
        cyc();
        flush     = 1'b1;
        issue_tag = 6'd3;
        cyc();
        vectors++;
        if (obs_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle: out_valid=%b, required 0", obs_valid);
        end
        sbq.delete();
        flush       = 1'b0;
        issue_valid = 1'b0;
        for (int i = 0; i < ST + 1; i++) begin
            cyc();
            vectors++;
            if (obs_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_after: cycle %0d out_valid=%b, required 0", i, obs_valid);
            end
        end
        vectors++;
        if (obs_done !== done_before) begin
            miscompares++;
            $display("FAIL flush_done: done=%0d, required %0d", obs_done, done_before);
        end
    endtask

    task automatic test_xlen64();
        v64    = 1'b1;
        func64 = 4'd0;
        opa64  = 64'hFFFF_FFFF_FFFF_FFFF;
        opb64  = 64'd1;
        tag64  = 6'd9;
        @(negedge clock);
        vectors++;
        if (rdy64 !== 1'b1 || ov64 !== 1'b0) begin
            miscompares++;
            $display("FAIL x64_issue: ready=%b valid=%b, required 1/0", rdy64, ov64);
        end
        @(posedge clock);
        #1;
        func64 = 4'd9;
        opa64  = 64'h8000_0000_0000_0000;
        opb64  = 64'h7F;
        tag64  = 6'd10;
        @(negedge clock);
        vectors++;
        if (ov64 !== 1'b1 || od64 !== 64'd0 || ot64 !== 6'd9) begin
            miscompares++;
            $display("FAIL x64_add: valid=%b data=%h tag=%0d, required 1/0/9", ov64, od64, ot64);
        end
        @(posedge clock);
        #1;
        v64 = 1'b0;
        @(negedge clock);
        vectors++;
        if (ov64 !== 1'b1 || od64 !== 64'hFFFF_FFFF_FFFF_FFFF || ot64 !== 6'd10 || done64 !== 32'd1) begin
            miscompares++;
            $display("FAIL x64_sra: valid=%b data=%h tag=%0d done=%0d, required 1/ffffffffffffffff/10/1", ov64, od64, ot64, done64);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_async_reset();
        exp_t e;
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        issue_func  = 4'd6;
        issue_opa   = 32'h1234;
        issue_opb   = 32'hFF;
        issue_tag   = 6'd4;
        cyc();
        cyc();
        issue_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || done_count !== 32'd0 || issue_ready !== 1'b1 || done64 !== 32'd0) begin
            miscompares++;
            $display("FAIL areset: valid=%b done=%0d ready=%b done64=%0d, required 0/0/1/0", out_valid, done_count, issue_ready, done64);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        sbq.delete();
        exp_done    = '0;
        out_ready   = 1'b1;
        issue_valid = 1'b1;
        issue_func  = 4'd0;
        issue_opa   = 32'd3;
        issue_opb   = 32'd4;
        issue_tag   = 6'd7;
        cyc();
        issue_valid = 1'b0;
        cyc();
        cyc();
        vectors++;
        e = (sbq.size() > 0) ? sbq.pop_front() : '0;
        if (!hs || hs_data !== 32'd7 || hs_tag !== 6'd7 || e.d !== 32'd7) begin
            miscompares++;
            $display("FAIL areset_resume: hs=%b data=%h tag=%0d, required 1/00000007/7", hs, hs_data, hs_tag);
        end
        cyc();
        vectors++;
        if (obs_done !== 32'd1) begin
            miscompares++;
            $display("FAIL areset_done: done=%0d, required 1", obs_done);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_flush();
        test_xlen64();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
